// File: rtl/mshr_entry_status_tracker.sv
// mshr_entry_status_tracker
//   Registered occupancy and selection tracker for the L1 dcache MSHR entry array.
//   Owns the per-entry valid vector, hands out the lowest free entry, accepts
//   several same-cycle releases and offers the next entry to retire through a
//   valid/ready handshake (lowest-index or round-robin pick).
//
// Ports
//   clk             : clock
//   rst_n           : synchronous active-low reset
//   alloc_valid_i   : allocation request
//   alloc_ready_o   : a free entry exists
//   alloc_idx_o     : lowest free index (0 when full)
//   release_valid_i : per-channel release strobe
//   release_idx_i   : packed release indices, channel k at [k*W +: W]
//   cancel_valid_o  : at least one valid entry
//   cancel_ready_i  : consumer accepts next2cancel_o
//   next2cancel_o   : entry offered for retirement (0 when empty)
//   used_o          : number of valid entries
//   empty_o/full_o  : occupancy flags
//   almost_full_o   : used_o >= ALMOST_FULL_TH
//   err_o           : sticky, a release hit an invalid entry
module mshr_entry_status_tracker #(
  parameter int unsigned NUM_ENTRY      = 4,
  parameter int unsigned NUM_RELEASE    = 2,
  parameter int unsigned ALMOST_FULL_TH = 3,
  parameter int unsigned PICK_MODE      = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   alloc_valid_i,
  output logic                                   alloc_ready_o,
  output logic [$clog2(NUM_ENTRY)-1:0]           alloc_idx_o,
  input  logic [NUM_RELEASE-1:0]                 release_valid_i,
  input  logic [NUM_RELEASE*$clog2(NUM_ENTRY)-1:0] release_idx_i,
  output logic                                   cancel_valid_o,
  input  logic                                   cancel_ready_i,
  output logic [$clog2(NUM_ENTRY)-1:0]           next2cancel_o,
  output logic [$clog2(NUM_ENTRY):0]             used_o,
  output logic                                   empty_o,
  output logic                                   full_o,
  output logic                                   almost_full_o,
  output logic                                   err_o
);

  localparam int unsigned W    = $clog2(NUM_ENTRY);
  localparam int unsigned CntW = W + 1;

  logic [NUM_ENTRY-1:0] r_valid;
  logic [W-1:0]         r_rr_ptr;
  logic                 r_err;
  logic [CntW-1:0]      r_used;

  logic [NUM_ENTRY-1:0] w_valid_d;
  logic [NUM_ENTRY-1:0] w_alloc_onehot;
  logic [NUM_ENTRY-1:0] w_cancel_onehot;
  logic [NUM_ENTRY-1:0] w_release_mask;
  logic [CntW-1:0]      w_used_d;
  logic                 w_rel_err;
  logic                 w_free_found;
  logic                 w_pick_found;
  logic                 w_alloc_fire;
  logic                 w_cancel_fire;

  // Lowest free entry.
  always_comb begin
    alloc_idx_o  = '0;
    w_free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        alloc_idx_o  = W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  // Retirement pick: probe upward from 0 or from the round-robin pointer,
  // relying on W-bit wraparound for the modulo.
  always_comb begin : pick
    logic [W-1:0] probe;
    probe         = '0;
    next2cancel_o = '0;
    w_pick_found  = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      probe = (PICK_MODE == 0) ? W'(i) : r_rr_ptr + W'(i);
      if (r_valid[probe] && !w_pick_found) begin
        next2cancel_o = probe;
        w_pick_found  = 1'b1;
      end
    end
  end

  assign alloc_ready_o  = w_free_found;
  assign cancel_valid_o = w_pick_found;
  assign w_alloc_fire   = alloc_valid_i & alloc_ready_o;
  assign w_cancel_fire  = cancel_valid_o & cancel_ready_i;

  assign w_alloc_onehot  = w_alloc_fire  ? (NUM_ENTRY'(1) << alloc_idx_o)   : '0;
  assign w_cancel_onehot = w_cancel_fire ? (NUM_ENTRY'(1) << next2cancel_o) : '0;

  // Release mask; duplicate channels collapse into one bit. An entry being
  // allocated this cycle is not an error target.
  always_comb begin : rel
    logic [W-1:0] ridx;
    ridx           = '0;
    w_release_mask = '0;
    w_rel_err      = 1'b0;
    for (int unsigned k = 0; k < NUM_RELEASE; k++) begin
      if (release_valid_i[k]) begin
        ridx                 = release_idx_i[k*W +: W];
        w_release_mask[ridx] = 1'b1;
        if (!r_valid[ridx] && !(w_alloc_fire && (ridx == alloc_idx_o))) begin
          w_rel_err = 1'b1;
        end
      end
    end
  end

  assign w_valid_d = (r_valid | w_alloc_onehot) & ~w_release_mask & ~w_cancel_onehot;

  always_comb begin
    w_used_d = '0;
    for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
      w_used_d = w_used_d + CntW'(w_valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
      r_used   <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_used  <= w_used_d;
      if (w_rel_err) begin
        r_err <= 1'b1;
      end
      if (w_cancel_fire) begin
        r_rr_ptr <= next2cancel_o + W'(1);
      end
    end
  end

  assign used_o        = r_used;
  assign empty_o       = (r_used == '0);
  assign full_o        = (r_used == CntW'(NUM_ENTRY));
  assign almost_full_o = (r_used >= CntW'(ALMOST_FULL_TH)) | full_o;
  assign err_o         = r_err;

endmodule

// File: tb/tb_mshr_entry_status_tracker.sv
// tb_mshr_entry_status_tracker
//   Drives one lowest-index instance and one round-robin instance with the same
//   stimulus. A behavioural model predicts each instance's outputs when a step is
//   driven; predictions queue up and are compared one cycle later.
module tb_mshr_entry_status_tracker;

  localparam int unsigned N  = 4;
  localparam int unsigned R  = 2;
  localparam int unsigned W  = 2;
  localparam int unsigned TH = 3;

  typedef struct packed {
    logic         ar;
    logic [W-1:0] ai;
    logic         cv;
    logic [W-1:0] nc;
    logic [W:0]   used;
    logic         em;
    logic         fu;
    logic         af;
    logic         er;
  } obs_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           alloc_valid = 1'b0;
  logic [R-1:0]   rel_v = '0;
  logic [R*W-1:0] rel_idx = '0;
  logic           cancel_ready = 1'b0;

  logic         ar0, ar1, cv0, cv1, em0, em1, fu0, fu1, af0, af1, er0, er1;
  logic [W-1:0] ai0, ai1, nc0, nc1;
  logic [W:0]   us0, us1;

  always #5 clk = ~clk;

  mshr_entry_status_tracker #(
    .NUM_ENTRY(N), .NUM_RELEASE(R), .ALMOST_FULL_TH(TH), .PICK_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .alloc_valid_i(alloc_valid), .alloc_ready_o(ar0),
    .alloc_idx_o(ai0), .release_valid_i(rel_v), .release_idx_i(rel_idx),
    .cancel_valid_o(cv0), .cancel_ready_i(cancel_ready), .next2cancel_o(nc0),
    .used_o(us0), .empty_o(em0), .full_o(fu0), .almost_full_o(af0), .err_o(er0)
  );

  mshr_entry_status_tracker #(
    .NUM_ENTRY(N), .NUM_RELEASE(R), .ALMOST_FULL_TH(TH), .PICK_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .alloc_valid_i(alloc_valid), .alloc_ready_o(ar1),
    .alloc_idx_o(ai1), .release_valid_i(rel_v), .release_idx_i(rel_idx),
    .cancel_valid_o(cv1), .cancel_ready_i(cancel_ready), .next2cancel_o(nc1),
    .used_o(us1), .empty_o(em1), .full_o(fu1), .almost_full_o(af1), .err_o(er1)
  );

  // Model state, index 0 = lowest-index pick, 1 = round-robin pick.
  logic [N-1:0] mv  [2];
  logic [W-1:0] mrr [2];
  logic         merr[2];
  obs_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic obs_t model_obs(input int m);
    obs_t o;
    int   cnt;
    int   j;
    o = '0;
    cnt = 0;
    for (int i = 0; i < int'(N); i++) if (mv[m][i]) cnt++;
    o.used = cnt[W:0];
    o.ar   = (cnt != int'(N));
    o.cv   = (cnt != 0);
    o.em   = (cnt == 0);
    o.fu   = (cnt == int'(N));
    o.af   = (cnt >= int'(TH));
    o.er   = merr[m];
    for (int i = int'(N) - 1; i >= 0; i--) if (!mv[m][i]) o.ai = i[W-1:0];
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = (m == 0) ? i : (int'(mrr[m]) + i) % int'(N);
      if (mv[m][j]) o.nc = j[W-1:0];
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = '0; mrr[m] = '0; merr[m] = 1'b0;
    end
  endtask

  task automatic model_step(input logic a, input logic [R-1:0] rv,
                            input logic [W-1:0] r0, input logic [W-1:0] r1, input logic cr);
    obs_t         cur;
    logic         afire, cfire;
    logic [N-1:0] mask, nv;
    logic [W-1:0] idx;
    for (int m = 0; m < 2; m++) begin
      cur   = model_obs(m);
      afire = a && cur.ar;
      cfire = cur.cv && cr;
      mask  = '0;
      for (int k = 0; k < int'(R); k++) begin
        if (rv[k]) begin
          idx = (k == 0) ? r0 : r1;
          mask[idx] = 1'b1;
          if (!mv[m][idx] && !(afire && cur.ai == idx)) merr[m] = 1'b1;
        end
      end
      nv = mv[m];
      if (afire) nv[cur.ai] = 1'b1;
      nv = nv & ~mask;
      if (cfire) begin
        nv[cur.nc] = 1'b0;
        mrr[m] = cur.nc + 1'b1;
      end
      mv[m] = nv;
    end
  endtask

  task automatic cmp(input string tag, input obs_t obs, input obs_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic obs_t dut_obs(input int m);
    if (m == 0) return {ar0, ai0, cv0, nc0, us0, em0, fu0, af0, er0};
    return {ar1, ai1, cv1, nc1, us1, em1, fu1, af1, er1};
  endfunction

  task automatic step(input string tag, input logic rst, input logic a,
                      input logic [R-1:0] rv, input logic [W-1:0] r0,
                      input logic [W-1:0] r1, input logic cr);
    obs_t e;
    @(negedge clk);
    rst_n        = rst;
    alloc_valid  = a;
    rel_v        = rv;
    rel_idx      = {r1, r0};
    cancel_ready = cr;
    if (!rst) model_reset();
    else model_step(a, rv, r0, r1, cr);
    sb.push_back(model_obs(0));
    sb.push_back(model_obs(1));
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL %s scoreboard empty", tag);
      end else begin
        e = sb.pop_front();
        cmp($sformatf("%s/dut%0d", tag, m), dut_obs(m), e);
      end
    end
  endtask

  initial begin
    obs_t rst_exp;
    rst_exp = '0;
    rst_exp.ar = 1'b1;
    rst_exp.em = 1'b1;

    step("rst", 0, 0, 0, 0, 0, 0);
    step("rst", 0, 0, 0, 0, 0, 0);
    cmp("rst_const0", dut_obs(0), rst_exp);
    cmp("rst_const1", dut_obs(1), rst_exp);

    // Fill, then one ignored alloc while full.
    for (int i = 0; i < 5; i++) step("alloc", 1, 1, 0, 0, 0, 0);
    step("rel12", 1, 0, 2'b11, 2'd1, 2'd2, 0);
    step("rel1_err", 1, 0, 2'b01, 2'd1, 2'd0, 0);

    // Duplicate release + cancel on the same entry.
    step("rst2", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("alloc", 1, 1, 0, 0, 0, 0);
    step("rel01", 1, 0, 2'b11, 2'd0, 2'd1, 0);
    step("rel2", 1, 0, 2'b01, 2'd2, 2'd0, 0);
    step("dup3", 1, 0, 2'b11, 2'd3, 2'd3, 1);

    // Drain a full array.
    for (int i = 0; i < 4; i++) step("alloc", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("drain", 1, 0, 0, 0, 0, 1);

    // Leave rr pointer at 3 with valid = {0,2}.
    for (int i = 0; i < 3; i++) step("alloc", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("drain", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("alloc", 1, 1, 0, 0, 0, 0);
    step("rel1", 1, 0, 2'b01, 2'd1, 2'd0, 0);
    step("hold", 1, 0, 0, 0, 0, 0);
    step("hold", 1, 0, 0, 0, 0, 0);
    step("wrap", 1, 0, 0, 0, 0, 1);
    step("realloc", 1, 1, 0, 0, 0, 0);
    step("split", 1, 0, 0, 0, 0, 1);
    step("split", 1, 0, 0, 0, 0, 1);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      step("rand", 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset with every event asserted.
    step("alloc", 1, 1, 0, 0, 0, 0);
    step("alloc", 1, 1, 0, 0, 0, 0);
    step("midrst", 0, 1, 2'b11, 2'd0, 2'd1, 1);
    cmp("midrst_const0", dut_obs(0), rst_exp);
    cmp("midrst_const1", dut_obs(1), rst_exp);
    step("post", 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
